// File: rtl/keccak_pkg.sv
// Shared Keccak sponge constants and the absorb-side state encoding.
package keccak_pkg;

  localparam int         RATE_SHAKE128 = 1344;
  localparam int         RATE_SHAKE256 = 1088;
  localparam logic [7:0] DSEP_SHAKE    = 8'h1F;
  localparam logic [7:0] DSEP_SHA3     = 8'h06;
  localparam logic [7:0] PAD_FINAL     = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    OUT  = 2'd2
  } absorb_state_t;

endpackage

// File: rtl/keccak_pad_insert.sv
// Combinational pad10*1 insertion: ORs the domain byte at pad_pos and 8'h80 into the last rate byte.
module keccak_pad_insert
  import keccak_pkg::*;
#(
  parameter int RATE_BITS = RATE_SHAKE256,
  parameter int POS_W     = 8
) (
  input  logic [RATE_BITS-1:0] buf_in,
  input  logic [POS_W-1:0]     pad_pos,
  input  logic [7:0]           dsep,
  output logic [RATE_BITS-1:0] buf_out
);

  localparam int RATE_BYTES = RATE_BITS / 8;

  always_comb begin
    buf_out = buf_in;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (pad_pos == POS_W'(i)) begin
        buf_out[8*i +: 8] = buf_in[8*i +: 8] | dsep;
      end
    end
    // Applied after the domain byte so both marks merge when pad_pos is the last byte.
    buf_out[RATE_BITS-8 +: 8] = buf_out[RATE_BITS-8 +: 8] | PAD_FINAL;
  end

endmodule

// File: rtl/keccak_absorb_packer.sv
// Packs byte-lane input beats into RATE_BITS sponge blocks and applies pad10*1 with a domain byte.
// Optional macro KECCAK_ABSORB_DSEP_PORT_EN adds a run-time dsep_in port sampled per message.
module keccak_absorb_packer
  import keccak_pkg::*;
#(
  parameter int         RATE_BITS = RATE_SHAKE256,
  parameter int         IN_W      = 64,
  parameter logic [7:0] DSEP      = DSEP_SHAKE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [$clog2(IN_W/8):0]   in_last_bytes,
  output logic [RATE_BITS-1:0]      blk_data,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic                      blk_last
`ifdef KECCAK_ABSORB_DSEP_PORT_EN
  ,
  input  logic [7:0]                dsep_in
`endif
);

  localparam int BEAT_BYTES = IN_W / 8;
  localparam int RATE_BYTES = RATE_BITS / 8;
  localparam int BPB        = RATE_BITS / IN_W;
  localparam int BI_W       = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int LB_W       = $clog2(BEAT_BYTES) + 1;
  localparam int PP_W       = $clog2(RATE_BYTES + 1);

  absorb_state_t          state_q, state_d;
  logic [BI_W-1:0]        beat_idx_q, beat_idx_d;
  logic [RATE_BITS-1:0]   blk_buf_q, blk_buf_d;
  logic [PP_W-1:0]        pad_pos_q, pad_pos_d;
  logic                   pad_pending_q, pad_pending_d;
  logic                   blk_last_q, blk_last_d;
  logic [RATE_BITS-1:0]   padded_buf;
  logic [7:0]             dsep_eff;
  logic [IN_W-1:0]        wdata;
  logic [LB_W-1:0]        nbytes;
  logic [PP_W-1:0]        pos;
  logic                   accept;

  // Illegal byte counts above a full beat are treated as a full beat.
  function automatic logic [LB_W-1:0] clamp_bytes(input logic [LB_W-1:0] n);
    return (n > LB_W'(BEAT_BYTES)) ? LB_W'(BEAT_BYTES) : n;
  endfunction

`ifdef KECCAK_ABSORB_DSEP_PORT_EN
  logic       msg_active_q, msg_active_d;
  logic [7:0] dsep_q, dsep_d;

  // The domain byte is latched on the first beat so it cannot change mid-message.
  always_comb begin
    msg_active_d = msg_active_q;
    dsep_d       = dsep_q;
    if (accept && !msg_active_q) begin
      msg_active_d = 1'b1;
      dsep_d       = dsep_in;
    end
    if (blk_valid && blk_ready && blk_last_q) begin
      msg_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_active_q <= 1'b0;
      dsep_q       <= DSEP;
    end else begin
      msg_active_q <= msg_active_d;
      dsep_q       <= dsep_d;
    end
  end

  assign dsep_eff = dsep_q;
`else
  assign dsep_eff = DSEP;
`endif

  assign in_ready  = (state_q == FILL) && !reset;
  assign accept    = in_valid && in_ready;
  assign blk_valid = (state_q == OUT);
  assign blk_data  = blk_buf_q;
  assign blk_last  = blk_last_q;

  keccak_pad_insert #(
    .RATE_BITS (RATE_BITS),
    .POS_W     (PP_W)
  ) u_pad_insert (
    .buf_in  (blk_buf_q),
    .pad_pos (pad_pos_q),
    .dsep    (dsep_eff),
    .buf_out (padded_buf)
  );

  always_comb begin
    state_d       = state_q;
    beat_idx_d    = beat_idx_q;
    blk_buf_d     = blk_buf_q;
    pad_pos_d     = pad_pos_q;
    pad_pending_d = pad_pending_q;
    blk_last_d    = blk_last_q;
    wdata         = in_data;
    nbytes        = clamp_bytes(in_last_bytes);
    pos           = PP_W'(beat_idx_q) * PP_W'(BEAT_BYTES) + PP_W'(nbytes);

    unique case (state_q)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < BEAT_BYTES; k++) begin
            if (in_last && (LB_W'(k) >= nbytes)) begin
              wdata[8*k +: 8] = 8'h00;
            end
          end
          for (int b = 0; b < BPB; b++) begin
            if (beat_idx_q == BI_W'(b)) begin
              blk_buf_d[b*IN_W +: IN_W] = wdata;
            end
          end
          if (in_last) begin
            pad_pos_d  = pos;
            beat_idx_d = '0;
            blk_last_d = 1'b0;
            // A block filled exactly by the message needs a second, padding-only block.
            if (pos == PP_W'(RATE_BYTES)) begin
              pad_pending_d = 1'b1;
              state_d       = OUT;
            end else begin
              state_d = PAD;
            end
          end else if (beat_idx_q == BI_W'(BPB - 1)) begin
            beat_idx_d = '0;
            blk_last_d = 1'b0;
            state_d    = OUT;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      PAD: begin
        blk_buf_d  = padded_buf;
        blk_last_d = 1'b1;
        state_d    = OUT;
      end
      OUT: begin
        if (blk_ready) begin
          blk_buf_d  = '0;
          blk_last_d = 1'b0;
          if (pad_pending_q) begin
            pad_pos_d     = '0;
            pad_pending_d = 1'b0;
            state_d       = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      beat_idx_q    <= '0;
      blk_buf_q     <= '0;
      pad_pos_q     <= '0;
      pad_pending_q <= 1'b0;
      blk_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_idx_q    <= beat_idx_d;
      blk_buf_q     <= blk_buf_d;
      pad_pos_q     <= pad_pos_d;
      pad_pending_q <= pad_pending_d;
      blk_last_q    <= blk_last_d;
    end
  end

endmodule
